// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   funct3 encodings, FSM state type, and small funct3 decode helpers.
package mdu_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Divide family occupies the upper half of the funct3 space.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == MULHSU_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

    // Remainder ops return the high (remainder) half of the divide accumulator.
    function automatic logic is_rem(input logic [2:0] f3);
        logic r;
        case (f3)
            REM_F3, REMU_F3: r = 1'b1;
            DIV_F3, DIVU_F3: r = 1'b0;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // MULH variants return the upper XLEN bits of the 2*XLEN product.
    function automatic logic high_half(input logic [2:0] f3);
        logic h;
        case (f3)
            MULH_F3, MULHSU_F3, MULHU_F3: h = 1'b1;
            MUL_F3:                       h = 1'b0;
            default:                      h = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate.
//   neg     : 1 = negate value, 0 = pass through
//   value   : XLEN-bit input
//   fixed_c : XLEN-bit combinational result
module mdu_signfix #(
    parameter int unsigned XLEN = 32
) (
    input  logic            neg,
    input  logic [XLEN-1:0] value,
    output logic [XLEN-1:0] fixed_c
);

    assign fixed_c = neg ? (~value) + XLEN'(1) : value;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit.
//   clk, reset     : clock, synchronous active-high reset
//   Start, Flush   : request (taken when Ready) / abort in-flight work
//   Funct3         : M-extension op select
//   SrcA, SrcB     : rs1 / rs2 operands
//   Ready, Busy    : idle / iterating
//   Done           : one-cycle pulse, Result valid
//   Result         : registered result, held until the next completion
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Ready,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_n;

    logic            pend;         // operands latched, FSM leaves IDLE next edge
    logic [2:0]      op;
    logic [XLEN-1:0] opnd;         // multiplicand (mul) or divisor (div) magnitude
    logic            neg_res;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;          // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

    logic            accept_c;
    logic            sa_c, sb_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c;
    logic            div_zero_c, ovf_c, special_c;
    logic [XLEN-1:0] special_val_c;
    logic [XLEN-1:0] hi_c, lo_c;
    logic [XLEN:0]   sum_c, rem_sh_c;
    logic [XLEN-1:0] trial_c;
    logic [PW-1:0]   acc_step_c, fix_in_c, fixed_c;
    logic [XLEN-1:0] res_c;

    assign accept_c = Start & Ready & ~Flush;

    // Operand magnitudes on the way in.
    assign sa_c = a_signed(Funct3) & SrcA[XLEN-1];
    assign sb_c = b_signed(Funct3) & SrcB[XLEN-1];

    mdu_signfix #(.XLEN(XLEN)) u_mag_a (.neg(sa_c), .value(SrcA), .fixed_c(mag_a_c));
    mdu_signfix #(.XLEN(XLEN)) u_mag_b (.neg(sb_c), .value(SrcB), .fixed_c(mag_b_c));

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        div_zero_c    = is_div(Funct3) && (SrcB == '0);
        ovf_c         = is_div(Funct3) && a_signed(Funct3) && (SrcA == MOST_NEG) && (SrcB == '1);
        special_c     = div_zero_c | ovf_c;
        special_val_c = SrcA;
        if (div_zero_c) begin
            special_val_c = is_rem(Funct3) ? SrcA : '1;
        end else if (ovf_c) begin
            special_val_c = is_rem(Funct3) ? '0 : SrcA;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        hi_c     = acc[PW-1:XLEN];
        lo_c     = acc[XLEN-1:0];
        sum_c    = {1'b0, hi_c} + {1'b0, opnd};
        rem_sh_c = {hi_c, lo_c[XLEN-1]};
        trial_c  = XLEN'(rem_sh_c - {1'b0, opnd});
        if (is_div(op)) begin
            // Remainder stays below the divisor, so XLEN bits hold it after either branch.
            if (rem_sh_c >= {1'b0, opnd}) begin
                acc_step_c = {trial_c, lo_c[XLEN-2:0], 1'b1};
            end else begin
                acc_step_c = {hi_c[XLEN-2:0], lo_c[XLEN-1], lo_c[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_c = {(lo_c[0] ? sum_c : {1'b0, hi_c}), lo_c[XLEN-1:1]};
        end
    end

    // Sign fixup of the final accumulator; it is registered into Result on entry to FIN.
    always_comb begin
        fix_in_c = acc_step_c;
        if (is_div(op)) begin
            fix_in_c = {XLEN'(0), (is_rem(op) ? acc_step_c[PW-1:XLEN] : acc_step_c[XLEN-1:0])};
        end
    end

    mdu_signfix #(.XLEN(PW)) u_fix (.neg(neg_res), .value(fix_in_c), .fixed_c(fixed_c));

    assign res_c = high_half(op) ? fixed_c[PW-1:XLEN] : fixed_c[XLEN-1:0];

    // Next-state logic; Flush overrides everything.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (pend) state_n = special ? FIN : RUN;
            RUN:  if (cnt == CW'(XLEN - 1)) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (Flush) state_n = IDLE;
    end

    // State, handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pend        <= 1'b0;
            Ready       <= 1'b1;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Result      <= '0;
            op          <= '0;
            opnd        <= '0;
            neg_res     <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            cnt         <= '0;
            acc         <= '0;
        end else begin
            state <= state_n;
            pend  <= accept_c;
            Ready <= (state_n == IDLE) && !accept_c;
            Busy  <= (state_n == RUN);
            Done  <= (state_n == FIN);

            if (accept_c) begin
                op          <= Funct3;
                opnd        <= is_div(Funct3) ? mag_b_c : mag_a_c;
                acc         <= {XLEN'(0), (is_div(Funct3) ? mag_a_c : mag_b_c)};
                neg_res     <= is_rem(Funct3) ? sa_c : (sa_c ^ sb_c);
                special     <= special_c;
                special_val <= special_val_c;
            end else if (state == RUN) begin
                acc <= acc_step_c;
            end

            cnt <= (state == RUN) ? cnt + CW'(1) : '0;

            if (state_n == FIN) begin
                Result <= (state == RUN) ? res_c : special_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): directed cases, handshake corner
// cases and random operations against an arithmetic reference model.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        Flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp;

    mdu_iter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Ready(Ready), .Busy(Busy), .Done(Done), .Result(Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // RISC-V M semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f3)
            MUL_F3:    begin p = ua * ub;           return p[31:0];  end
            MULH_F3:   begin p = sa * sb;           return p[63:32]; end
            MULHSU_F3: begin p = sa * longint'(ub); return p[63:32]; end
            MULHU_F3:  begin p = ua * ub;           return p[63:32]; end
            DIV_F3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            DIVU_F3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            REM_F3: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Issue one op from a negedge with Ready=1; optionally re-pulse Start at cycle start_at.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int start_at, input string tag);
        logic [31:0] exp;
        int lat_exp, busy_exp, lat, busy_n, ready_n;
        exp      = ref_model(f3, a, b);
        lat_exp  = is_special(f3, a, b) ? 1 : 33;
        busy_exp = is_special(f3, a, b) ? 0 : 32;
        chk({tag, "_ready_idle"}, 64'(Ready), 64'd1);
        Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; SrcA = $urandom(); SrcB = $urandom(); Funct3 = 3'($urandom());
        lat = -1; busy_n = 0; ready_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            Start = 1'b0;
            if (Ready) ready_n++;
            if (Done) begin
                lat = k;
                break;
            end
            if (Busy) busy_n++;
            if (k == start_at) begin
                Start = 1'b1; SrcA = $urandom(); SrcB = $urandom(); Funct3 = 3'($urandom());
            end
        end
        Start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_result"}, 64'(Result), 64'(exp));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(busy_exp));
        chk({tag, "_ready_low"}, 64'(ready_n), 64'd0);
        last_exp = exp;
        @(posedge clk); @(negedge clk);
        chk({tag, "_ready_after"}, 64'(Ready), 64'd1);
        chk({tag, "_result_hold"}, 64'(Result), 64'(exp));
    endtask

    // Watch a window with no Done pulse and Result unchanged.
    task automatic quiet_window(input string tag);
        int done_n;
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_n++;
        end
        chk({tag, "_no_done"}, 64'(done_n), 64'd0);
        chk({tag, "_result_kept"}, 64'(Result), 64'(last_exp));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int unsigned r;

        reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
        last_exp = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(Ready), 64'd1);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_result", 64'(Result), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(MUL_F3,    32'd7,          32'hFFFF_FFFD, -1, "mul");
        do_op(MULH_F3,   32'h8000_0000,  32'h8000_0000, -1, "mulh");
        do_op(MULHU_F3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, "mulhu");
        do_op(MULHSU_F3, 32'hFFFF_FFFF,  32'd2,         -1, "mulhsu");
        do_op(DIV_F3,    32'hFFFF_FFF9,  32'd2,         -1, "div");
        do_op(REM_F3,    32'hFFFF_FFF9,  32'd2,         -1, "rem");
        do_op(DIVU_F3,   32'hFFFF_FFF9,  32'd2,         -1, "divu");
        do_op(REMU_F3,   32'hFFFF_FFF9,  32'd2,         -1, "remu");
        do_op(DIV_F3,    32'd5,          32'd0,         -1, "div_by0");
        do_op(REMU_F3,   32'd5,          32'd0,         -1, "remu_by0");
        do_op(DIV_F3,    32'h8000_0000,  32'hFFFF_FFFF, -1, "div_ovf");
        do_op(REM_F3,    32'h8000_0000,  32'hFFFF_FFFF, -1, "rem_ovf");

        // Start pulse while busy must be ignored.
        do_op(DIVU_F3, 32'd1000, 32'd7, 5, "divu_ignore_start");

        // Flush mid-operation.
        Start = 1'b1; Funct3 = DIVU_F3; SrcA = $urandom(); SrcB = $urandom() | 32'd1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(negedge clk);
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(Ready), 64'd1);
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_done", 64'(Done), 64'd0);
        quiet_window("flush");

        // Flush together with Start: nothing is accepted.
        Start = 1'b1; Flush = 1'b1; Funct3 = MUL_F3; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge clk);
        chk("flush_start_ready", 64'(Ready), 64'd1);
        chk("flush_start_busy", 64'(Busy), 64'd0);
        quiet_window("flush_start");

        // Reset in the middle of a multiply.
        Start = 1'b1; Funct3 = MUL_F3; SrcA = $urandom(); SrcB = $urandom();
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_ready", 64'(Ready), 64'd1);
        chk("midreset_busy", 64'(Busy), 64'd0);
        chk("midreset_done", 64'(Done), 64'd0);
        chk("midreset_result", 64'(Result), 64'd0);
        do_op(MULHU_F3, 32'd3, 32'd5, -1, "mulhu_after_reset");

        // Random operations, biased toward the special divide cases.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom());
            a  = $urandom();
            b  = $urandom();
            r  = $urandom_range(0, 7);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = 32'h8000_0000;
            do_op(f3, a, b, -1, $sformatf("rand%0d_f%0d", i, f3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
